// File: rtl/tank_move_ctrl.sv
// ---------------------------------------------------------------------------
// tank_move_ctrl
//
// Per-frame motion scheduler for the player tank sprite. Once per video frame,
// on the vsync rising edge, the four direction buttons are sampled. The next
// tank position is computed with a speed ramp and clamped to the playfield.
// The result is then published to the tank generator as one atomic update,
// so the drawn sprite never moves mid-frame.
//
// Sequence after a frame start:
//   IDLE -> CALC -> CLAMP -> PUBLISH -> IDLE
// A frame start that arrives outside IDLE is dropped, not queued.
//
// Ports
//   clk          in   1   pixel clock (single clock domain)
//   rst          in   1   asynchronous, active-low reset
//   vsync        in   1   frame sync from the timing generator
//   freeze       in   1   1 = menu/select mode, no motion
//   btn_up       in   1   level-held, synchronous to clk
//   btn_down     in   1   level-held, synchronous to clk
//   btn_left     in   1   level-held, synchronous to clk
//   btn_right    in   1   level-held, synchronous to clk
//   Data_out_X   out  10  published tank X
//   Data_out_Y   out  10  published tank Y
//   moving       out  1   last published update changed the position
//   wall_hit     out  1   one-cycle pulse when the last update was clamped
//   update_done  out  1   one-cycle pulse on publish
// ---------------------------------------------------------------------------
module tank_move_ctrl #(
   parameter int X_MIN        = 0,
   parameter int X_MAX        = 960,
   parameter int Y_MIN        = 0,
   parameter int Y_MAX        = 704,
   parameter int X_INIT       = 100,
   parameter int Y_INIT       = 600,
   parameter int SPEED_MAX    = 4,
   parameter int ACCEL_FRAMES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vsync,
   input  logic       freeze,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   output logic [9:0] Data_out_X,
   output logic [9:0] Data_out_Y,
   output logic       moving,
   output logic       wall_hit,
   output logic       update_done
);

   localparam int         AXES        = 2;      // index 0 = X, 1 = Y
   localparam logic [2:0] SPEED_MAX_C = 3'(SPEED_MAX);
   localparam logic [7:0] ACCEL_C     = 8'(ACCEL_FRAMES);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CALC    = 2'd1,
      ST_CLAMP   = 2'd2,
      ST_PUBLISH = 2'd3
   } state_t;

   state_t state_reg, state_next;

   // Frame-start detection
   logic vsync_q_reg;
   logic frame_start;

   // Speed ramp
   logic [2:0] speed_reg;
   logic [7:0] hold_cnt_reg;

   // Per-axis datapath (packed so whole-vector compares stay simple)
   logic [AXES-1:0][9:0]  pos_reg;       // published position
   logic [AXES-1:0][11:0] cand_reg;      // signed candidate from CALC
   logic [AXES-1:0][11:0] cand_next;
   logic [AXES-1:0][9:0]  clamped_reg;   // bounded position from CLAMP
   logic [AXES-1:0][9:0]  clamped_next;
   logic [AXES-1:0]       clamp_hit;
   logic                  clamp_flag_reg;

   // Direction decode: "pos" moves toward larger coordinates.
   // Y grows downward on screen, so down is the positive Y direction.
   logic [AXES-1:0] btn_pos;
   logic [AXES-1:0] btn_neg;
   logic [AXES-1:0] dir_pos;
   logic [AXES-1:0] dir_neg;
   logic            any_motion;

   logic signed [11:0] step_s;

   // Output registers
   logic moving_reg;
   logic wall_hit_reg;
   logic update_done_reg;

   assign frame_start = vsync & ~vsync_q_reg;

   assign btn_pos = {btn_down, btn_right};
   assign btn_neg = {btn_up,   btn_left};

   // The step always uses the speed held before this frame's ramp update.
   assign step_s = $signed({9'd0, speed_reg});

   genvar gi;
   generate
      for (gi = 0; gi < AXES; gi = gi + 1) begin : g_axis
         localparam logic signed [11:0] LO_BOUND = 12'((gi == 0) ? X_MIN : Y_MIN);
         localparam logic signed [11:0] HI_BOUND = 12'((gi == 0) ? X_MAX : Y_MAX);

         logic signed [11:0] base_s;
         logic signed [11:0] cand_s;
         logic               below_lo;
         logic               above_hi;

         // Opposing buttons cancel; freeze suppresses both directions.
         assign dir_pos[gi] = btn_pos[gi] & ~btn_neg[gi] & ~freeze;
         assign dir_neg[gi] = btn_neg[gi] & ~btn_pos[gi] & ~freeze;

         // Candidate is kept signed 12-bit so a step past 0 goes negative
         // instead of wrapping to a large unsigned value.
         assign base_s        = $signed({2'b00, pos_reg[gi]});
         assign cand_next[gi] = dir_pos[gi] ? (base_s + step_s) :
                                dir_neg[gi] ? (base_s - step_s) : base_s;

         assign cand_s   = $signed(cand_reg[gi]);
         assign below_lo = (cand_s < LO_BOUND);
         assign above_hi = (cand_s > HI_BOUND);

         assign clamped_next[gi] = below_lo ? LO_BOUND[9:0] :
                                   above_hi ? HI_BOUND[9:0] : cand_s[9:0];
         assign clamp_hit[gi]    = below_lo | above_hi;
      end
   endgenerate

   assign any_motion = |{dir_pos, dir_neg};

   // -----------------------------------------------------------------------
   // State register
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // -----------------------------------------------------------------------
   // Next-state logic
   // -----------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:    if (frame_start) state_next = ST_CALC;
         ST_CALC:    state_next = ST_CLAMP;
         ST_CLAMP:   state_next = ST_PUBLISH;
         ST_PUBLISH: state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // -----------------------------------------------------------------------
   // Datapath and outputs
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vsync_q_reg     <= 1'b0;
         speed_reg       <= 3'd1;
         hold_cnt_reg    <= 8'd0;
         pos_reg[0]      <= 10'(X_INIT);
         pos_reg[1]      <= 10'(Y_INIT);
         cand_reg        <= '0;
         clamped_reg     <= '0;
         clamp_flag_reg  <= 1'b0;
         moving_reg      <= 1'b0;
         wall_hit_reg    <= 1'b0;
         update_done_reg <= 1'b0;
      end else begin
         vsync_q_reg     <= vsync;
         wall_hit_reg    <= 1'b0;
         update_done_reg <= 1'b0;

         case (state_reg)
            ST_CALC: begin
               cand_reg <= cand_next;
               if (any_motion) begin
                  if (hold_cnt_reg + 8'd1 == ACCEL_C) begin
                     hold_cnt_reg <= 8'd0;
                     if (speed_reg < SPEED_MAX_C) begin
                        speed_reg <= speed_reg + 3'd1;
                     end
                  end else begin
                     hold_cnt_reg <= hold_cnt_reg + 8'd1;
                  end
               end else begin
                  // Any idle or frozen frame restarts the ramp.
                  speed_reg    <= 3'd1;
                  hold_cnt_reg <= 8'd0;
               end
            end

            ST_CLAMP: begin
               clamped_reg    <= clamped_next;
               clamp_flag_reg <= |clamp_hit;
            end

            ST_PUBLISH: begin
               pos_reg         <= clamped_reg;
               moving_reg      <= (clamped_reg != pos_reg);
               wall_hit_reg    <= clamp_flag_reg;
               update_done_reg <= 1'b1;
            end

            default: ;
         endcase
      end
   end

   assign Data_out_X  = pos_reg[0];
   assign Data_out_Y  = pos_reg[1];
   assign moving      = moving_reg;
   assign wall_hit    = wall_hit_reg;
   assign update_done = update_done_reg;

endmodule

// File: tb/tb_tank_move_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tank_move_ctrl
//
// Self-checking bench for tank_move_ctrl. A behavioural model tracks the
// position, speed and hold count frame by frame using plain integer
// arithmetic. Each scenario task drives frames and compares the DUT's
// published outputs inline.
// ---------------------------------------------------------------------------
module tb_tank_move_ctrl;

   localparam int X_MIN        = 0;
   localparam int X_MAX        = 960;
   localparam int Y_MIN        = 0;
   localparam int Y_MAX        = 704;
   localparam int X_INIT       = 100;
   localparam int Y_INIT       = 600;
   localparam int SPEED_MAX    = 4;
   localparam int ACCEL_FRAMES = 8;

   // Button vectors are {up, down, left, right}
   localparam logic [3:0] B_NONE  = 4'b0000;
   localparam logic [3:0] B_RIGHT = 4'b0001;
   localparam logic [3:0] B_LEFT  = 4'b0010;
   localparam logic [3:0] B_DOWN  = 4'b0100;
   localparam logic [3:0] B_UP_RT = 4'b1001;
   localparam logic [3:0] B_UP_LR = 4'b1011;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       vsync = 1'b0;
   logic       freeze = 1'b0;
   logic       btn_up = 1'b0;
   logic       btn_down = 1'b0;
   logic       btn_left = 1'b0;
   logic       btn_right = 1'b0;
   logic [9:0] Data_out_X;
   logic [9:0] Data_out_Y;
   logic       moving;
   logic       wall_hit;
   logic       update_done;

   int n_checks = 0;
   int n_fail   = 0;
   int frame_no = 0;

   // Reference model state
   int m_x, m_y, m_speed, m_hold;

   tank_move_ctrl #(
      .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
      .X_INIT(X_INIT), .Y_INIT(Y_INIT),
      .SPEED_MAX(SPEED_MAX), .ACCEL_FRAMES(ACCEL_FRAMES)
   ) dut (
      .clk(clk), .rst(rst), .vsync(vsync), .freeze(freeze),
      .btn_up(btn_up), .btn_down(btn_down),
      .btn_left(btn_left), .btn_right(btn_right),
      .Data_out_X(Data_out_X), .Data_out_Y(Data_out_Y),
      .moving(moving), .wall_hit(wall_hit), .update_done(update_done)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------
   // Reference model: one frame of motion from the button rules
   // ---------------------------------------------------------------------
   task automatic model_reset();
      m_x = X_INIT; m_y = Y_INIT; m_speed = 1; m_hold = 0;
   endtask

   task automatic model_frame(input logic [3:0] btn, input logic frz,
                              output int ex, output int ey,
                              output logic emov, output logic ewall);
      int dx, dy, nx, ny;
      dx = int'(btn[0]) - int'(btn[1]);   // right - left
      dy = int'(btn[2]) - int'(btn[3]);   // down - up
      if (frz) begin dx = 0; dy = 0; end
      nx = m_x + dx * m_speed;
      ny = m_y + dy * m_speed;
      ewall = 1'b0;
      if (nx < X_MIN) begin nx = X_MIN; ewall = 1'b1; end
      else if (nx > X_MAX) begin nx = X_MAX; ewall = 1'b1; end
      if (ny < Y_MIN) begin ny = Y_MIN; ewall = 1'b1; end
      else if (ny > Y_MAX) begin ny = Y_MAX; ewall = 1'b1; end
      emov = (nx != m_x) || (ny != m_y);
      if (dx != 0 || dy != 0) begin
         m_hold++;
         if (m_hold == ACCEL_FRAMES) begin
            m_hold = 0;
            if (m_speed < SPEED_MAX) m_speed++;
         end
      end else begin
         m_speed = 1;
         m_hold  = 0;
      end
      m_x = nx; m_y = ny;
      ex = nx; ey = ny;
   endtask

   // ---------------------------------------------------------------------
   // Stimulus: one vsync pulse, then wait (bounded) for update_done.
   // Returns the cycle count to the pulse and the published outputs.
   // With scramble set, buttons/freeze are randomized once CALC is past.
   // ---------------------------------------------------------------------
   task automatic run_frame(input logic [3:0] btn, input logic frz, input bit scramble,
                            output int lat, output logic [9:0] ox, output logic [9:0] oy,
                            output logic omov, output logic owall, output logic odone_after);
      @(negedge clk);
      {btn_up, btn_down, btn_left, btn_right} = btn;
      freeze = frz;
      vsync  = 1'b1;
      lat    = -1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) vsync = 1'b0;
         if (c == 2 && scramble) begin
            {btn_up, btn_down, btn_left, btn_right} = 4'($urandom);
            freeze = 1'($urandom);
         end
         if (update_done === 1'b1) begin
            lat = c;
            break;
         end
      end
      ox    = Data_out_X;
      oy    = Data_out_Y;
      omov  = moving;
      owall = wall_hit;
      @(negedge clk);
      odone_after = update_done;
      {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
      freeze = 1'b0;
      frame_no++;
      $display("frame %0d btn=%b frz=%b -> X=%0d Y=%0d moving=%b wall=%b lat=%0d",
               frame_no, btn, frz, ox, oy, omov, owall, lat);
   endtask

   task automatic do_reset();
      vsync = 1'b0; freeze = 1'b0;
      {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      model_reset();
   endtask

   // ---------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------
   task automatic test_reset();
      int pulses;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (Data_out_X !== 10'd100) begin n_fail++; $display("FAIL reset_x got %0d want 100", Data_out_X); end
      n_checks++; if (Data_out_Y !== 10'd600) begin n_fail++; $display("FAIL reset_y got %0d want 600", Data_out_Y); end
      n_checks++; if ({moving, wall_hit, update_done} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {moving, wall_hit, update_done}); end
      rst = 1'b1;
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (update_done !== 1'b0) pulses++;
      end
      n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL reset_no_update got %0d pulses want 0", pulses); end
      n_checks++; if (Data_out_X !== 10'd100 || Data_out_Y !== 10'd600) begin n_fail++; $display("FAIL reset_hold got (%0d,%0d) want (100,600)", Data_out_X, Data_out_Y); end
      model_reset();
      $display("reset done: X=%0d Y=%0d", Data_out_X, Data_out_Y);
   endtask

   task automatic test_ramp();
      int lat;
      logic [9:0] ox, oy;
      logic om, ow, od;
      int exp_x [10] = '{101, 102, 103, 104, 105, 106, 107, 108, 110, 112};
      int ex, ey;
      logic em, ew;
      do_reset();
      for (int f = 0; f < 10; f++) begin
         model_frame(B_RIGHT, 1'b0, ex, ey, em, ew);
         run_frame(B_RIGHT, 1'b0, 1'b0, lat, ox, oy, om, ow, od);
         n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL ramp_latency f%0d got %0d want 4", f, lat); end
         n_checks++; if (ox !== 10'(exp_x[f])) begin n_fail++; $display("FAIL ramp_x f%0d got %0d want %0d", f, ox, exp_x[f]); end
         n_checks++; if (oy !== 10'd600) begin n_fail++; $display("FAIL ramp_y f%0d got %0d want 600", f, oy); end
         n_checks++; if (om !== 1'b1 || ow !== 1'b0) begin n_fail++; $display("FAIL ramp_flags f%0d got mov=%b wall=%b want 1,0", f, om, ow); end
         n_checks++; if (od !== 1'b0) begin n_fail++; $display("FAIL ramp_pulse_width f%0d got %b want 0", f, od); end
      end
   endtask

   task automatic test_cancel();
      int lat;
      logic [9:0] ox, oy;
      logic om, ow, od;
      do_reset();
      run_frame(B_UP_LR, 1'b0, 1'b0, lat, ox, oy, om, ow, od);
      n_checks++; if (ox !== 10'd100 || oy !== 10'd599) begin n_fail++; $display("FAIL cancel_pos got (%0d,%0d) want (100,599)", ox, oy); end
      n_checks++; if (om !== 1'b1 || ow !== 1'b0) begin n_fail++; $display("FAIL cancel_flags got mov=%b wall=%b want 1,0", om, ow); end
      model_reset();
   endtask

   task automatic test_wall();
      int lat, ex, ey;
      logic [9:0] ox, oy;
      logic om, ow, od, em, ew;
      logic [3:0] b;
      do_reset();
      // Two right, one idle, then a long hold: lands exactly on X = 958 at speed 4.
      for (int f = 0; f < 233; f++) begin
         b = (f < 2 || f >= 3) ? B_RIGHT : B_NONE;
         model_frame(b, 1'b0, ex, ey, em, ew);
         run_frame(b, 1'b0, 1'b0, lat, ox, oy, om, ow, od);
         if (f == 228) begin
            n_checks++; if (ox !== 10'd958) begin n_fail++; $display("FAIL wall_approach got %0d want 958", ox); end
         end
         if (f >= 229) begin
            n_checks++; if (ox !== 10'd960 || ow !== 1'b1) begin n_fail++; $display("FAIL wall_clamp f%0d got X=%0d wall=%b want 960,1", f, ox, ow); end
            n_checks++; if (om !== (f == 229)) begin n_fail++; $display("FAIL wall_moving f%0d got %b want %b", f, om, (f == 229)); end
         end
         n_checks++; if (ox !== 10'(ex) || oy !== 10'(ey) || om !== em || ow !== ew || lat !== 4 || od !== 1'b0) begin
            n_fail++; $display("FAIL wall_model f%0d got X=%0d Y=%0d mov=%b wall=%b lat=%0d want X=%0d Y=%0d mov=%b wall=%b lat=4", f, ox, oy, om, ow, lat, ex, ey, em, ew);
         end
      end
      // Up+right into the corner: Y runs down to 0 and then clamps.
      for (int f = 0; f < 153; f++) begin
         model_frame(B_UP_RT, 1'b0, ex, ey, em, ew);
         run_frame(B_UP_RT, 1'b0, 1'b0, lat, ox, oy, om, ow, od);
         n_checks++; if (ox !== 10'(ex) || oy !== 10'(ey) || om !== em || ow !== ew || lat !== 4) begin
            n_fail++; $display("FAIL corner_model f%0d got X=%0d Y=%0d mov=%b wall=%b lat=%0d want X=%0d Y=%0d mov=%b wall=%b", f, ox, oy, om, ow, lat, ex, ey, em, ew);
         end
      end
      n_checks++; if (oy !== 10'd0) begin n_fail++; $display("FAIL corner_y got %0d want 0", oy); end
   endtask

   task automatic test_freeze();
      int lat, ex, ey;
      logic [9:0] ox, oy, y_frozen;
      logic om, ow, od, em, ew;
      logic frz;
      do_reset();
      // Ramp to speed 2, freeze for 5 frames, then release.
      for (int f = 0; f < 15; f++) begin
         frz = (f >= 9 && f < 14);
         model_frame(B_DOWN, frz, ex, ey, em, ew);
         run_frame(B_DOWN, frz, 1'b0, lat, ox, oy, om, ow, od);
         if (f == 9) y_frozen = oy;
         if (frz) begin
            n_checks++; if (om !== 1'b0 || oy !== 10'd610) begin n_fail++; $display("FAIL freeze_hold f%0d got Y=%0d mov=%b want 610,0", f, oy, om); end
         end
         n_checks++; if (ox !== 10'(ex) || oy !== 10'(ey) || om !== em || ow !== ew || lat !== 4) begin
            n_fail++; $display("FAIL freeze_model f%0d got X=%0d Y=%0d mov=%b wall=%b lat=%0d want X=%0d Y=%0d", f, ox, oy, om, ow, lat, ex, ey);
         end
      end
      n_checks++; if (oy !== y_frozen + 10'd1) begin n_fail++; $display("FAIL freeze_release got %0d want %0d", oy, y_frozen + 10'd1); end
   endtask

   task automatic test_reset_mid();
      int lat, ex, ey, pulses;
      logic [9:0] ox, oy;
      logic om, ow, od, em, ew;
      do_reset();
      for (int f = 0; f < 3; f++) begin
         model_frame(B_RIGHT, 1'b0, ex, ey, em, ew);
         run_frame(B_RIGHT, 1'b0, 1'b0, lat, ox, oy, om, ow, od);
      end
      n_checks++; if (ox !== 10'd103) begin n_fail++; $display("FAIL midrst_pre got %0d want 103", ox); end
      @(negedge clk); btn_right = 1'b1; vsync = 1'b1;
      @(negedge clk); vsync = 1'b0;          // CALC
      @(negedge clk);                        // CLAMP
      rst = 1'b0;
      #1;
      n_checks++; if (Data_out_X !== 10'd100 || Data_out_Y !== 10'd600 || moving !== 1'b0 || update_done !== 1'b0) begin
         n_fail++; $display("FAIL midrst_abort got X=%0d Y=%0d mov=%b done=%b want 100,600,0,0", Data_out_X, Data_out_Y, moving, update_done);
      end
      btn_right = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (update_done !== 1'b0) pulses++;
      end
      n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL midrst_no_update got %0d want 0", pulses); end
      model_reset();
      model_frame(B_RIGHT, 1'b0, ex, ey, em, ew);
      run_frame(B_RIGHT, 1'b0, 1'b0, lat, ox, oy, om, ow, od);
      n_checks++; if (ox !== 10'(ex) || oy !== 10'(ey) || lat !== 4) begin n_fail++; $display("FAIL midrst_resume got X=%0d Y=%0d lat=%0d want %0d,%0d,4", ox, oy, lat, ex, ey); end
   endtask

   task automatic test_vsync_edges();
      int pulses, ex, ey;
      logic em, ew;
      do_reset();
      // vsync held high for a long time: one update only.
      @(negedge clk); btn_right = 1'b1; vsync = 1'b1;
      pulses = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (update_done === 1'b1) pulses++;
      end
      vsync = 1'b0; btn_right = 1'b0;
      repeat (3) @(negedge clk);
      model_frame(B_RIGHT, 1'b0, ex, ey, em, ew);
      n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL vsync_held got %0d updates want 1", pulses); end
      n_checks++; if (Data_out_X !== 10'(ex)) begin n_fail++; $display("FAIL vsync_held_x got %0d want %0d", Data_out_X, ex); end
      $display("vsync held: updates=%0d X=%0d", pulses, Data_out_X);
      // Second rising edge while busy is dropped.
      @(negedge clk); btn_left = 1'b1; vsync = 1'b1;
      pulses = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) vsync = 1'b0;
         if (c == 2) vsync = 1'b1;
         if (c == 3) vsync = 1'b0;
         if (update_done === 1'b1) pulses++;
      end
      btn_left = 1'b0;
      model_frame(B_LEFT, 1'b0, ex, ey, em, ew);
      n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL busy_edge got %0d updates want 1", pulses); end
      n_checks++; if (Data_out_X !== 10'(ex)) begin n_fail++; $display("FAIL busy_edge_x got %0d want %0d", Data_out_X, ex); end
      $display("busy edge: updates=%0d X=%0d", pulses, Data_out_X);
   endtask

   task automatic test_random();
      int lat, ex, ey;
      logic [9:0] ox, oy;
      logic om, ow, od, em, ew, frz;
      logic [3:0] b;
      do_reset();
      for (int f = 0; f < 150; f++) begin
         b   = 4'($urandom);
         frz = ($urandom_range(0, 7) == 0);
         model_frame(b, frz, ex, ey, em, ew);
         run_frame(b, frz, 1'b1, lat, ox, oy, om, ow, od);
         n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL rand_latency f%0d got %0d want 4", f, lat); end
         n_checks++; if (ox !== 10'(ex) || oy !== 10'(ey)) begin n_fail++; $display("FAIL rand_pos f%0d got (%0d,%0d) want (%0d,%0d)", f, ox, oy, ex, ey); end
         n_checks++; if (om !== em || ow !== ew) begin n_fail++; $display("FAIL rand_flags f%0d got mov=%b wall=%b want %b,%b", f, om, ow, em, ew); end
         n_checks++; if (od !== 1'b0) begin n_fail++; $display("FAIL rand_pulse_width f%0d got %b want 0", f, od); end
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_cancel();
      test_wall();
      test_freeze();
      test_reset_mid();
      test_vsync_edges();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tank_move_ctrl.md
# tank_move_ctrl

Per-frame motion scheduler for the player tank sprite. Samples four direction buttons once per video frame, on the vsync rising edge. Computes the next tank position with speed ramp-up and screen-edge clamping. Publishes the new position atomically to the `Data_in_X` and `Data_in_Y` inputs of the tank generator, so the drawn sprite never changes mid-frame.

## Interface
Parameters:
- `X_MIN`, default 0: leftmost allowed X.
- `X_MAX`, default 960: rightmost allowed X (1024 minus 64-pixel tank width).
- `Y_MIN`, default 0: topmost allowed Y.
- `Y_MAX`, default 704: bottommost allowed Y.
- `X_INIT`, default 100: X position after reset.
- `Y_INIT`, default 600: Y position after reset.
- `SPEED_MAX`, default 4: maximum step in pixels per frame (1..7).
- `ACCEL_FRAMES`, default 8: held frames per +1 speed increment (1..255).

Ports:
- `clk`  in  1  pixel clock; one clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `vsync`  in  1  frame sync from the timing generator.
- `freeze`  in  1  1 = menu/select mode; no motion.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  level-held, already synchronized to `clk`.
- `Data_out_X`  out  10  published tank X.
- `Data_out_Y`  out  10  published tank Y.
- `moving`  out  1  1 while last published update moved the tank.
- `wall_hit`  out  1  one-cycle pulse when a clamp occurred.
- `update_done`  out  1  one-cycle pulse on publish.

## Operation
Frame-start detection:
- `vsync_q` is a one-cycle registered copy of `vsync`.
- `frame_start` = `vsync & ~vsync_q`.

State machine: IDLE -> CALC -> CLAMP -> PUBLISH -> IDLE.
- IDLE: wait for `frame_start`. A `frame_start` seen in any other state is ignored (not queued).
- CALC: latch the buttons and compute `dx`, `dy` in {-1, 0, +1}.
  - Up and down together give `dy` = 0; left and right together give `dx` = 0.
  - `freeze` = 1 forces `dx` = `dy` = 0.
  - Speed update:
    - If `dx` or `dy` is nonzero, increment `hold_cnt`. When `hold_cnt` reaches `ACCEL_FRAMES`, clear it and increment `speed` (saturates at `SPEED_MAX`).
    - Otherwise set `speed` = 1 and `hold_cnt` = 0.
  - Candidate positions: `nx = X + dx*speed`, `ny = Y + dy*speed`, computed as 12-bit signed. The speed used is the value before this frame's increment.
- CLAMP: `nx < X_MIN` gives `X_MIN`; `nx > X_MAX` gives `X_MAX`; same rule for Y. Any clamp sets internal `clamp_flag`.
- PUBLISH:
  - Write the clamped values to `Data_out_X` and `Data_out_Y`.
  - Set `moving` = 1 if the position changed, else 0.
  - Pulse `update_done`; pulse `wall_hit` if `clamp_flag`.
  - Return to IDLE.
- Diagonal motion steps both axes by `speed`; there is no normalization.
- Outputs change only in PUBLISH and hold otherwise.

## Timing
- Reset values (async assert, clocked release): state IDLE; `Data_out_X` = `X_INIT`; `Data_out_Y` = `Y_INIT`; `speed` = 1; `hold_cnt` = 0; `moving`, `wall_hit`, `update_done` = 0; `vsync_q` = 0.
- Latency: `vsync` sampled high at edge N (with `vsync_q` low) gives CALC at N+1, CLAMP at N+2, PUBLISH at N+3. New outputs and the pulses are visible after edge N+3.
- Publish completes 4 cycles after frame start, well inside vertical blanking. The tank generator sees a stable position for the whole active frame.
- Buttons are sampled only in CALC; changes at any other time have no effect until the next frame.
- Reset asserted mid-sequence aborts it. No partial position is ever published.
- `freeze` rising mid-hold resets the speed ramp at the next CALC.
- Already at the wall and pushing into it: position unchanged, `moving` = 0, `wall_hit` pulses every frame.
- `vsync` held high for many cycles gives exactly one update.

## Test plan
- Reset: release `rst` -> `Data_out_X` = 100, `Data_out_Y` = 600, all flags 0, no `update_done` before the first `vsync` edge.
- Hold `btn_right` for 10 frames from X = 100 -> X sequence 101…108 (8 steps at speed 1), then 110, 112 (speed 2 from frame 9); `update_done` once per frame, 4 cycles after the edge.
- Left and right plus `btn_up` together from (100, 600) -> X stays 100, Y = 599; `moving` = 1.
- Start X = 958, hold right at speed 4 -> next X = 960, `wall_hit` pulse; further frames keep X = 960, `moving` = 0, `wall_hit` each frame.
- `freeze` = 1 with `btn_down` held for 5 frames -> position constant, `speed` stays 1; release `freeze` -> Y increments by 1.
- Pull `rst` low at the CLAMP cycle after 3 moving frames -> outputs return to (100, 600); no `update_done` that frame; normal updates resume at the next `vsync` edge.
